// File: rtl/inst_pkg.sv
// Shared decode-stage definitions: opcode/funct constants, ALU operation
// encodings, MIPS field positions and the immediate-extension helper.
package inst_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Field positions in MIPS bit numbering (bit 31 = opcode MSB).
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SH_MSB    = 10;
  localparam int unsigned SH_LSB    = 6;
  localparam int unsigned FN_MSB    = 5;
  localparam int unsigned FN_LSB    = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned JADDR_MSB = 25;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_PASS = 4'hF
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_write;
    logic    reg_dst_rd;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE    = '{alu_op: ALU_ADD,  default: 1'b0};
  localparam ctrl_t CTRL_ILLEGAL = '{alu_op: ALU_PASS, illegal: 1'b1, default: 1'b0};

  // Only andi/ori zero-extend; every other format (including R-type, j and
  // illegal words) presents the sign-extended low half-word.
  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
    logic [31:0] ext;
    if (zero_ext) begin
      ext = {16'h0000, imm};
    end else begin
      ext = {{16{imm[15]}}, imm};
    end
    return ext;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear, r0 hardwired to zero.
module reg_file
  import inst_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Storage array: cleared by clr, written on any enabled non-r0 write-back.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_r[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_r[raddr_b];

endmodule

// File: rtl/inst_decode.sv
// Decode stage: splits a fetched MIPS-subset word into fields and control,
// reads both operands with write-back bypass, and holds the result in a
// one-entry valid/ready output register.
module inst_decode
  import inst_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [32:1] inst_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [31:0] imm_ext,
  output logic [25:0] jaddr,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        reg_dst_rd,
  output logic        alu_src_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  logic [31:0] instr_s;
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [15:0] imm16_s;
  logic [25:0] jaddr_s;
  ctrl_t       ctrl_s;
  logic        zero_ext_s;
  logic [31:0] rf_a_s;
  logic [31:0] rf_b_s;
  logic [31:0] opnd_a_s;
  logic [31:0] opnd_b_s;
  logic        wb_live_s;
  logic        in_fire_s;

  logic        out_valid_r;
  logic [4:0]  rs_r;
  logic [4:0]  rt_r;
  logic [4:0]  rd_r;
  logic [4:0]  shamt_r;
  logic [31:0] imm_r;
  logic [25:0] jaddr_r;
  logic [31:0] rdata_a_r;
  logic [31:0] rdata_b_r;
  ctrl_t       ctrl_r;

  // inst_in[k+1] carries MIPS bit k, so a plain copy restores MIPS numbering.
  assign instr_s  = inst_in;
  assign opcode_s = instr_s[OP_MSB:OP_LSB];
  assign rs_s     = instr_s[RS_MSB:RS_LSB];
  assign rt_s     = instr_s[RT_MSB:RT_LSB];
  assign rd_s     = instr_s[RD_MSB:RD_LSB];
  assign shamt_s  = instr_s[SH_MSB:SH_LSB];
  assign funct_s  = instr_s[FN_MSB:FN_LSB];
  assign imm16_s  = instr_s[IMM_MSB:0];
  assign jaddr_s  = instr_s[JADDR_MSB:0];

  assign in_ready  = !out_valid_r || out_ready;
  assign in_fire_s = in_valid && in_ready;

  reg_file u_reg_file (
    .clk     (clk),
    .clr     (clr),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_s),
    .raddr_b (rt_s),
    .rdata_a (rf_a_s),
    .rdata_b (rf_b_s)
  );

  // A write landing in the capture cycle is not yet in the array; forward it.
  assign wb_live_s = wb_en && (wb_addr != 5'd0);
  assign opnd_a_s  = (wb_live_s && (wb_addr == rs_s)) ? wb_data : rf_a_s;
  assign opnd_b_s  = (wb_live_s && (wb_addr == rt_s)) ? wb_data : rf_b_s;

  // Opcode/funct to control-word decode.
  always_comb begin
    ctrl_s     = CTRL_ILLEGAL;
    zero_ext_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        ctrl_s            = CTRL_NONE;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.reg_dst_rd = 1'b1;
        case (funct_s)
          FN_ADD:  ctrl_s.alu_op = ALU_ADD;
          FN_SUB:  ctrl_s.alu_op = ALU_SUB;
          FN_AND:  ctrl_s.alu_op = ALU_AND;
          FN_OR:   ctrl_s.alu_op = ALU_OR;
          FN_SLT:  ctrl_s.alu_op = ALU_SLT;
          FN_SLL:  ctrl_s.alu_op = ALU_SLL;
          FN_SRL:  ctrl_s.alu_op = ALU_SRL;
          default: ctrl_s = CTRL_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        ctrl_s             = CTRL_NONE;
        ctrl_s.alu_op      = ALU_ADD;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.reg_write   = 1'b1;
      end
      OP_ANDI: begin
        ctrl_s             = CTRL_NONE;
        ctrl_s.alu_op      = ALU_AND;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.reg_write   = 1'b1;
        zero_ext_s         = 1'b1;
      end
      OP_ORI: begin
        ctrl_s             = CTRL_NONE;
        ctrl_s.alu_op      = ALU_OR;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.reg_write   = 1'b1;
        zero_ext_s         = 1'b1;
      end
      OP_LW: begin
        ctrl_s             = CTRL_NONE;
        ctrl_s.alu_op      = ALU_ADD;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.mem_read    = 1'b1;
        ctrl_s.reg_write   = 1'b1;
      end
      OP_SW: begin
        ctrl_s             = CTRL_NONE;
        ctrl_s.alu_op      = ALU_ADD;
        ctrl_s.alu_src_imm = 1'b1;
        ctrl_s.mem_write   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_s        = CTRL_NONE;
        ctrl_s.alu_op = ALU_SUB;
        ctrl_s.branch = 1'b1;
      end
      OP_J: begin
        ctrl_s        = CTRL_NONE;
        ctrl_s.alu_op = ALU_PASS;
        ctrl_s.jump   = 1'b1;
      end
      default: begin
        ctrl_s     = CTRL_ILLEGAL;
        zero_ext_s = 1'b0;
      end
    endcase
  end

  // Output bundle register: load on accept, drop valid on drain, else hold.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_valid_r <= 1'b0;
      rs_r        <= 5'd0;
      rt_r        <= 5'd0;
      rd_r        <= 5'd0;
      shamt_r     <= 5'd0;
      imm_r       <= 32'd0;
      jaddr_r     <= 26'd0;
      rdata_a_r   <= 32'd0;
      rdata_b_r   <= 32'd0;
      ctrl_r      <= CTRL_NONE;
    end else if (in_fire_s) begin
      out_valid_r <= 1'b1;
      rs_r        <= rs_s;
      rt_r        <= rt_s;
      rd_r        <= rd_s;
      shamt_r     <= shamt_s;
      imm_r       <= ext_imm(imm16_s, zero_ext_s);
      jaddr_r     <= jaddr_s;
      rdata_a_r   <= opnd_a_s;
      rdata_b_r   <= opnd_b_s;
      ctrl_r      <= ctrl_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid   = out_valid_r;
  assign rs          = rs_r;
  assign rt          = rt_r;
  assign rd          = rd_r;
  assign shamt       = shamt_r;
  assign imm_ext     = imm_r;
  assign jaddr       = jaddr_r;
  assign rdata_a     = rdata_a_r;
  assign rdata_b     = rdata_b_r;
  assign alu_op      = ctrl_r.alu_op;
  assign reg_write   = ctrl_r.reg_write;
  assign reg_dst_rd  = ctrl_r.reg_dst_rd;
  assign alu_src_imm = ctrl_r.alu_src_imm;
  assign mem_read    = ctrl_r.mem_read;
  assign mem_write   = ctrl_r.mem_write;
  assign branch      = ctrl_r.branch;
  assign jump        = ctrl_r.jump;
  assign illegal     = ctrl_r.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: hand-derived vector table, directed
// stall/reset sequences and randomized traffic against a behavioural model.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        clr;
  logic [32:1] inst_in;
  logic        in_valid;
  logic        in_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;
  logic [31:0] rdata_a, rdata_b;
  logic [3:0]  alu_op;
  logic        reg_write, reg_dst_rd, alu_src_imm, mem_read, mem_write;
  logic        branch, jump, illegal;

  inst_decode dut (
    .clk(clk), .clr(clr), .inst_in(inst_in), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm_ext(imm_ext), .jaddr(jaddr),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst_rd(reg_dst_rd), .alu_src_imm(alu_src_imm),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // ctl = {reg_write, reg_dst_rd, alu_src_imm, mem_read, mem_write, branch, jump, illegal}
  typedef struct packed {
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic [25:0] jaddr;
    logic [31:0] ra, rb;
    logic [3:0]  alu;
    logic [7:0]  ctl;
  } bundle_t;

  typedef struct {
    logic [31:0] word;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm, ra, rb;
    logic [3:0]  alu;
    logic [7:0]  ctl;
  } vec_t;

  int          n_checks = 0;
  int          n_err    = 0;
  logic        m_valid;
  bundle_t     m_bundle;
  logic [31:0] m_regs [32];
  logic        collect = 1'b0;
  logic [15:0] delivered [$];
  logic [5:0]  legal_fn  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
  logic [5:0]  legal_ops [8] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
  vec_t        vecs [18];

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.rs = rs; b.rt = rt; b.rd = rd; b.shamt = shamt;
    b.imm = imm_ext; b.jaddr = jaddr; b.ra = rdata_a; b.rb = rdata_b; b.alu = alu_op;
    b.ctl = {reg_write, reg_dst_rd, alu_src_imm, mem_read, mem_write, branch, jump, illegal};
    return b;
  endfunction

  // Reference decode computed straight from the opcode/funct table.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] ra, input logic [31:0] rb);
    bundle_t     b;
    logic [31:0] op, fn, lo;
    op      = w >> 26;
    fn      = w & 32'd63;
    lo      = w & 32'hFFFF;
    b.rs    = 5'((w >> 21) & 32'd31);
    b.rt    = 5'((w >> 16) & 32'd31);
    b.rd    = 5'((w >> 11) & 32'd31);
    b.shamt = 5'((w >> 6) & 32'd31);
    b.imm   = (lo >= 32'd32768) ? lo + 32'hFFFF0000 : lo;
    b.jaddr = 26'(w & 32'h03FFFFFF);
    b.ra    = ra;
    b.rb    = rb;
    b.alu   = 4'hF;
    b.ctl   = 8'h01;
    if (op == 32'd0) begin
      for (int i = 0; i < 7; i++) begin
        if (fn == 32'(legal_fn[i])) begin
          b.alu = 4'(i);
          b.ctl = 8'hC0;
        end
      end
    end else if (op == 32'h08) begin
      b.alu = 4'd0; b.ctl = 8'hA0;
    end else if (op == 32'h0C) begin
      b.imm = lo; b.alu = 4'd2; b.ctl = 8'hA0;
    end else if (op == 32'h0D) begin
      b.imm = lo; b.alu = 4'd3; b.ctl = 8'hA0;
    end else if (op == 32'h23) begin
      b.alu = 4'd0; b.ctl = 8'hB0;
    end else if (op == 32'h2B) begin
      b.alu = 4'd0; b.ctl = 8'h28;
    end else if (op == 32'h04) begin
      b.alu = 4'd1; b.ctl = 8'h04;
    end else if (op == 32'h02) begin
      b.alu = 4'hF; b.ctl = 8'h02;
    end
    return b;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && (wb_addr == r)) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_bundle = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  // One clock: check in_ready, advance the model, then check the registered bundle.
  task automatic tick();
    logic        m_ir;
    logic [31:0] w;
    #1;
    m_ir = !m_valid || out_ready;
    check("in_ready", 160'(in_ready), 160'(m_ir));
    if (collect && out_valid && out_ready) delivered.push_back(imm_ext[15:0]);
    if (in_valid && m_ir) begin
      w        = inst_in;
      m_bundle = ref_decode(w, m_read(5'(w >> 21)), m_read(5'(w >> 16)));
      m_valid  = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && (wb_addr != 5'd0)) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
    check("out_valid", 160'(out_valid), 160'(m_valid));
    check("bundle", 160'(dut_bundle()), 160'(m_bundle));
  endtask

  function automatic logic [31:0] rand_word(input logic [4:0] hot);
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 8) w[31:26] = legal_ops[k];
    if ((w[31:26] == 6'h00) && ($urandom_range(0, 3) != 0)) w[5:0] = legal_fn[$urandom_range(0, 6)];
    if ($urandom_range(0, 1) == 1) w[25:21] = hot;
    if ($urandom_range(0, 2) == 0) w[20:16] = hot;
    return w;
  endfunction

  initial begin
    bundle_t     eb;
    logic [31:0] w;
    int          idx;
    logic        fired;

    //            word          wbe   wba    wbd           rs     rt     rd     sh     imm            ra            rb            alu    ctl
    vecs[0]  = '{32'h20080005, 1'b0, 5'd0, 32'h0,      5'd0, 5'd8,  5'd0,  5'd0,  32'h00000005, 32'h0,     32'h0,     4'd0, 8'hA0};
    vecs[1]  = '{32'h2128FFFF, 1'b0, 5'd0, 32'h0,      5'd9, 5'd8,  5'd31, 5'd31, 32'hFFFFFFFF, 32'h0,     32'h0,     4'd0, 8'hA0};
    vecs[2]  = '{32'h3108FFFF, 1'b0, 5'd0, 32'h0,      5'd8, 5'd8,  5'd31, 5'd31, 32'h0000FFFF, 32'h0,     32'h0,     4'd2, 8'hA0};
    vecs[3]  = '{32'h3528FFFF, 1'b0, 5'd0, 32'h0,      5'd9, 5'd8,  5'd31, 5'd31, 32'h0000FFFF, 32'h0,     32'h0,     4'd3, 8'hA0};
    vecs[4]  = '{32'h01095020, 1'b1, 5'd8, 32'h1234,   5'd8, 5'd9,  5'd10, 5'd0,  32'h00005020, 32'h1234,  32'h0,     4'd0, 8'hC0};
    vecs[5]  = '{32'h01085822, 1'b0, 5'd0, 32'h0,      5'd8, 5'd8,  5'd11, 5'd0,  32'h00005822, 32'h1234,  32'h1234,  4'd1, 8'hC0};
    vecs[6]  = '{32'h00000820, 1'b1, 5'd0, 32'hDEAD,   5'd0, 5'd0,  5'd1,  5'd0,  32'h00000820, 32'h0,     32'h0,     4'd0, 8'hC0};
    vecs[7]  = '{32'h000010C0, 1'b0, 5'd0, 32'h0,      5'd0, 5'd0,  5'd2,  5'd3,  32'h000010C0, 32'h0,     32'h0,     4'd5, 8'hC0};
    vecs[8]  = '{32'h00081842, 1'b0, 5'd0, 32'h0,      5'd0, 5'd8,  5'd3,  5'd1,  32'h00001842, 32'h0,     32'h1234,  4'd6, 8'hC0};
    vecs[9]  = '{32'h01082025, 1'b0, 5'd0, 32'h0,      5'd8, 5'd8,  5'd4,  5'd0,  32'h00002025, 32'h1234,  32'h1234,  4'd3, 8'hC0};
    vecs[10] = '{32'h0108282A, 1'b0, 5'd0, 32'h0,      5'd8, 5'd8,  5'd5,  5'd0,  32'h0000282A, 32'h1234,  32'h1234,  4'd4, 8'hC0};
    vecs[11] = '{32'h01083024, 1'b0, 5'd0, 32'h0,      5'd8, 5'd8,  5'd6,  5'd0,  32'h00003024, 32'h1234,  32'h1234,  4'd2, 8'hC0};
    vecs[12] = '{32'h8D09FFFC, 1'b0, 5'd0, 32'h0,      5'd8, 5'd9,  5'd31, 5'd31, 32'hFFFFFFFC, 32'h1234,  32'h0,     4'd0, 8'hB0};
    vecs[13] = '{32'hAD080010, 1'b0, 5'd0, 32'h0,      5'd8, 5'd8,  5'd0,  5'd0,  32'h00000010, 32'h1234,  32'h1234,  4'd0, 8'h28};
    vecs[14] = '{32'h11008000, 1'b0, 5'd0, 32'h0,      5'd8, 5'd0,  5'd16, 5'd0,  32'hFFFF8000, 32'h1234,  32'h0,     4'd1, 8'h04};
    vecs[15] = '{32'h08ABCDEF, 1'b0, 5'd0, 32'h0,      5'd5, 5'd11, 5'd25, 5'd23, 32'hFFFFCDEF, 32'h0,     32'h0,     4'hF, 8'h02};
    vecs[16] = '{32'hFC000000, 1'b0, 5'd0, 32'h0,      5'd0, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h0,     32'h0,     4'hF, 8'h01};
    vecs[17] = '{32'h0000003F, 1'b0, 5'd0, 32'h0,      5'd0, 5'd0,  5'd0,  5'd0,  32'h0000003F, 32'h0,     32'h0,     4'hF, 8'h01};

    clr = 1'b1; inst_in = 32'd0; in_valid = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 160'(out_valid), 160'd0);
    check("reset_bundle", 160'(dut_bundle()), 160'd0);
    check("reset_in_ready", 160'(in_ready), 160'd1);
    clr = 1'b0;

    // Table: back-to-back accepts with out_ready held high.
    for (int i = 0; i < 18; i++) begin
      inst_in = vecs[i].word; in_valid = 1'b1; out_ready = 1'b1;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      tick();
      w  = vecs[i].word;
      eb = '{vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].shamt, vecs[i].imm, w[25:0],
             vecs[i].ra, vecs[i].rb, vecs[i].alu, vecs[i].ctl};
      check($sformatf("vec%0d", i), 160'(dut_bundle()), 160'(eb));
      check($sformatf("vec%0d_valid", i), 160'(out_valid), 160'd1);
    end
    in_valid = 1'b0; wb_en = 1'b0;
    tick();

    // Stall sequence: eight addi words, out_ready low for three cycles then one more.
    idx = 0; collect = 1'b1;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c inside {2, 3, 4, 7});
      in_valid  = (idx < 8);
      inst_in   = 32'h20010000 | 32'(idx + 1);
      fired     = in_valid && (!m_valid || out_ready);
      tick();
      if (fired) idx++;
    end
    collect = 1'b0;
    check("stall_count", 160'(delivered.size()), 160'd8);
    for (int i = 0; i < delivered.size() && i < 8; i++) begin
      check($sformatf("stall_order%0d", i), 160'(delivered[i]), 160'(i + 1));
    end

    // Randomized traffic with write-back collisions on a few hot registers.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      wb_en     = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      inst_in   = rand_word(wb_addr);
      tick();
    end

    // Async clear between edges while a bundle is stalled.
    inst_in = 32'h20080005; in_valid = 1'b1; out_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'hCAFE;
    tick();
    out_ready = 1'b0; wb_en = 1'b0;
    tick();
    check("pre_clr_valid", 160'(out_valid), 160'd1);
    #2;
    clr = 1'b1;
    #1;
    check("clr_async_valid", 160'(out_valid), 160'd0);
    check("clr_async_bundle", 160'(dut_bundle()), 160'd0);
    model_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
    inst_in = 32'h01095020; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("rf_cleared", 160'(rdata_a), 160'd0);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
